fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single write port of one fifo instance

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter family.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ArbIdle,
        ArbLocked
    } arb_state_e;

    // Modular increment with an explicit compare, so non-power-of-2 counts wrap correctly.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority scan: first set bit of req at or after prio, wrapping.
module rr_pick #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdW    = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdW-1:0]    prio,
    output logic [IdW-1:0]    idx,
    output logic              found
);

    always_comb begin
        logic [IdW:0] cand;
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        idx   = prio;
        found = 1'b0;
        cand  = '0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            // prio + off stays below 2*NumReq, so one conditional subtract is the whole modulo.
            cand = {1'b0, prio} + (IdW+1)'(off);
            if (cand >= (IdW+1)'(NumReq)) begin
                cand = cand - (IdW+1)'(NumReq);
            end
            if (!found && req[cand[IdW-1:0]]) begin
                idx   = cand[IdW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port; multi-beat packets hold the grant until last.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned  NumReq = 4,
    parameter int unsigned  Width  = 32,
    localparam int unsigned IdW    = $clog2(NumReq)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumReq-1:0]            req_valid_i,
    input  logic [NumReq-1:0][Width-1:0] req_data_i,
    input  logic [NumReq-1:0]            req_last_i,
    output logic [NumReq-1:0]            req_ready_o,
    output logic                         fifo_wr_valid_o,
    output logic [Width-1:0]             fifo_wr_data_o,
    input  logic                         fifo_wr_ready_i,
    output logic [IdW-1:0]               grant_id_o,
    output logic                         locked_o
);

    arb_state_e     state_q, state_d;
    logic [IdW-1:0] owner_q, owner_d;
    logic [IdW-1:0] prio_q,  prio_d;

    logic [IdW-1:0] pick_idx;
    logic           pick_found;
    logic [IdW-1:0] grant_id;
    logic           grant_valid;
    logic           xfer;

    rr_pick #(
        .NumReq (NumReq),
        .IdW    (IdW)
    ) u_pick (
        .req   (req_valid_i),
        .prio  (prio_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        grant_id    = prio_q;
        grant_valid = 1'b0;

        case (state_q)
            ArbIdle: begin
                grant_id    = pick_idx;
                grant_valid = pick_found;
            end
            ArbLocked: begin
                // The owner keeps the port even while it bubbles.
                grant_id    = owner_q;
                grant_valid = req_valid_i[owner_q];
            end
            default: ;
        endcase

        xfer = grant_valid && fifo_wr_ready_i;

        if (xfer) begin
            if (req_last_i[grant_id]) begin
                state_d = ArbIdle;
                prio_d  = IdW'(rr_next(32'(grant_id), NumReq));
            end else begin
                state_d = ArbLocked;
                owner_d = grant_id;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (xfer) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    assign fifo_wr_valid_o = grant_valid;
    assign fifo_wr_data_o  = req_data_i[grant_id];
    assign grant_id_o      = grant_id;
    assign locked_o        = (state_q == ArbLocked);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            state_q <= ArbIdle;
            owner_q <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(req_ready_o));

    a_locked_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        locked_o |-> (grant_id_o == owner_q));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, corner sequences, random vs. model.
module tb_fifo_wr_arbiter;

    logic              clk_i;
    logic              rst_ni;

    logic [3:0]        req_valid;
    logic [3:0][31:0]  req_data;
    logic [3:0]        req_last;
    logic [3:0]        req_ready;
    logic              fifo_valid;
    logic [31:0]       fifo_data;
    logic              fifo_ready;
    logic [1:0]        grant_id;
    logic              locked;

    logic [2:0]        v3;
    logic [2:0][31:0]  d3;
    logic [2:0]        l3;
    logic [2:0]        ry3;
    logic              fv3;
    logic [31:0]       fd3;
    logic              r3;
    logic [1:0]        gid3;
    logic              lk3;

    int n_checks = 0;
    int n_fail   = 0;

    int m_owner;
    int m_prio;

    fifo_wr_arbiter #(.NumReq(4), .Width(32)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid),
        .req_data_i      (req_data),
        .req_last_i      (req_last),
        .req_ready_o     (req_ready),
        .fifo_wr_valid_o (fifo_valid),
        .fifo_wr_data_o  (fifo_data),
        .fifo_wr_ready_i (fifo_ready),
        .grant_id_o      (grant_id),
        .locked_o        (locked)
    );

    fifo_wr_arbiter #(.NumReq(3), .Width(32)) dut3 (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (v3),
        .req_data_i      (d3),
        .req_last_i      (l3),
        .req_ready_o     (ry3),
        .fifo_wr_valid_o (fv3),
        .fifo_wr_data_o  (fd3),
        .fifo_wr_ready_i (r3),
        .grant_id_o      (gid3),
        .locked_o        (lk3)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       rdy;
        int         gid;
        logic       fv;
        logic [3:0] ry;
        logic       lk;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a packet owner (or -1) and a priority pointer; winner found by modular search.
    task automatic model_eval(input logic [3:0] v, output int gid, output bit gv);
        gv  = 1'b0;
        gid = m_prio;
        if (m_owner >= 0) begin
            gid = m_owner;
            gv  = v[m_owner];
        end else begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_prio + k) % 4;
                if (!gv && v[c]) begin
                    gid = c;
                    gv  = 1'b1;
                end
            end
        end
    endtask

    task automatic model_step(input logic [3:0] v, input logic [3:0] l, input logic rdy);
        int g;
        bit gv;
        model_eval(v, g, gv);
        if (gv && rdy) begin
            if (l[g]) begin
                m_owner = -1;
                m_prio  = (g + 1) % 4;
            end else begin
                m_owner = g;
            end
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_prio  = 0;
    endtask

    task automatic drive_and_check(input string tag, input logic [3:0] v, input logic [3:0] l,
                                   input logic rdy, input int e_gid, input logic e_fv,
                                   input logic [3:0] e_rdy, input logic e_lk);
        req_valid  = v;
        req_last   = l;
        fifo_ready = rdy;
        #1;
        check({tag, ".valid"},  32'(fifo_valid), 32'(e_fv));
        check({tag, ".grant"},  32'(grant_id),   32'(e_gid));
        check({tag, ".ready"},  32'(req_ready),  32'(e_rdy));
        check({tag, ".locked"}, 32'(locked),     32'(e_lk));
        if (e_fv) begin
            check({tag, ".data"}, fifo_data, req_data[e_gid]);
        end
        model_step(v, l, rdy);
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive3(input string tag, input logic [2:0] v, input logic [2:0] l,
                          input int e_gid, input logic [2:0] e_rdy);
        v3 = v;
        l3 = l;
        r3 = 1'b1;
        #1;
        check({tag, ".grant"}, 32'(gid3), 32'(e_gid));
        check({tag, ".ready"}, 32'(ry3),  32'(e_rdy));
        check({tag, ".data"},  fd3,       d3[e_gid]);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [3:0] rv, rl, acc, e_ready;
        logic       rr;
        int         e_gid;
        bit         e_gv;

        rst_ni     = 1'b0;
        req_valid  = '0;
        req_last   = '0;
        fifo_ready = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i] = 32'hA0 + 32'(i);
        v3 = '0;
        l3 = '0;
        r3 = 1'b1;
        for (int i = 0; i < 3; i++) d3[i] = 32'hB0 + 32'(i);
        model_reset();

        #2;
        check("rst.locked", 32'(locked),     32'd0);
        check("rst.grant",  32'(grant_id),   32'd0);
        check("rst.valid",  32'(fifo_valid), 32'd0);
        check("rst.ready",  32'(req_ready),  32'd0);
        check("rst.grant3", 32'(gid3),       32'd0);

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Three requesters: move prio to 2, single beat from req2 wraps prio to 0.
        drive3("n3_r1",   3'b010, 3'b010, 1, 3'b010);
        drive3("n3_r2",   3'b100, 3'b100, 2, 3'b100);
        drive3("n3_wrap", 3'b011, 3'b011, 0, 3'b001);
        v3 = '0;

        // Single-beat round robin.
        tbl.push_back('{4'b1111, 4'b1111, 1'b1, 0, 1'b1, 4'b0001, 1'b0});
        tbl.push_back('{4'b1111, 4'b1111, 1'b1, 1, 1'b1, 4'b0010, 1'b0});
        tbl.push_back('{4'b1111, 4'b1111, 1'b1, 2, 1'b1, 4'b0100, 1'b0});
        tbl.push_back('{4'b1111, 4'b1111, 1'b1, 3, 1'b1, 4'b1000, 1'b0});
        tbl.push_back('{4'b1111, 4'b1111, 1'b1, 0, 1'b1, 4'b0001, 1'b0});
        // Req1 three-beat packet with req2 waiting.
        tbl.push_back('{4'b0110, 4'b0000, 1'b1, 1, 1'b1, 4'b0010, 1'b0});
        tbl.push_back('{4'b0110, 4'b0000, 1'b1, 1, 1'b1, 4'b0010, 1'b1});
        tbl.push_back('{4'b0110, 4'b0010, 1'b1, 1, 1'b1, 4'b0010, 1'b1});
        tbl.push_back('{4'b0100, 4'b0100, 1'b1, 2, 1'b1, 4'b0100, 1'b0});
        // Owner bubbles for two cycles while others are valid.
        tbl.push_back('{4'b1000, 4'b0000, 1'b1, 3, 1'b1, 4'b1000, 1'b0});
        tbl.push_back('{4'b0111, 4'b0111, 1'b1, 3, 1'b0, 4'b0000, 1'b1});
        tbl.push_back('{4'b0111, 4'b0111, 1'b1, 3, 1'b0, 4'b0000, 1'b1});
        tbl.push_back('{4'b1111, 4'b1000, 1'b1, 3, 1'b1, 4'b1000, 1'b1});
        // Fifo full for three cycles with req0 mid-packet.
        tbl.push_back('{4'b0001, 4'b0000, 1'b1, 0, 1'b1, 4'b0001, 1'b0});
        tbl.push_back('{4'b0011, 4'b0000, 1'b0, 0, 1'b1, 4'b0000, 1'b1});
        tbl.push_back('{4'b0011, 4'b0000, 1'b0, 0, 1'b1, 4'b0000, 1'b1});
        tbl.push_back('{4'b0011, 4'b0000, 1'b0, 0, 1'b1, 4'b0000, 1'b1});
        tbl.push_back('{4'b0011, 4'b0001, 1'b1, 0, 1'b1, 4'b0001, 1'b1});
        // Idle while full: grant may move before any beat is taken.
        tbl.push_back('{4'b0100, 4'b0100, 1'b0, 2, 1'b1, 4'b0000, 1'b0});
        tbl.push_back('{4'b0110, 4'b0110, 1'b0, 1, 1'b1, 4'b0000, 1'b0});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1, 1'b0, 4'b0000, 1'b0});

        foreach (tbl[i]) begin
            drive_and_check($sformatf("vec%0d", i), tbl[i].v, tbl[i].l, tbl[i].rdy,
                            tbl[i].gid, tbl[i].fv, tbl[i].ry, tbl[i].lk);
        end

        // Reset asserted mid-packet: state clears asynchronously.
        drive_and_check("lock2", 4'b0100, 4'b0000, 1'b1, 2, 1'b1, 4'b0100, 1'b0);
        req_valid = '0;
        rst_ni    = 1'b0;
        #1;
        check("midrst.locked", 32'(locked),     32'd0);
        check("midrst.grant",  32'(grant_id),   32'd0);
        check("midrst.valid",  32'(fifo_valid), 32'd0);
        check("midrst.ready",  32'(req_ready),  32'd0);
        #3;
        rst_ni = 1'b1;
        model_reset();
        #1;
        drive_and_check("post_rst", 4'b1000, 4'b1000, 1'b1, 3, 1'b1, 4'b1000, 1'b0);

        // Random traffic against the reference model, honouring valid/ready hold.
        rst_ni = 1'b0;
        req_valid = '0;
        #2;
        rst_ni = 1'b1;
        model_reset();
        rv  = '0;
        rl  = '0;
        acc = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!(rv[i] && !acc[i])) begin
                    rv[i]       = ($urandom_range(0, 2) != 0);
                    rl[i]       = 1'($urandom_range(0, 1));
                    req_data[i] = $urandom;
                end
            end
            rr = ($urandom_range(0, 3) != 0);
            model_eval(rv, e_gid, e_gv);
            e_ready = (e_gv && rr) ? (4'b0001 << e_gid) : 4'b0000;
            drive_and_check($sformatf("rnd%0d", cyc), rv, rl, rr, e_gid, e_gv, e_ready,
                            m_owner >= 0);
            acc = e_ready;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
